keccak_squeeze: RTL and testbench

Output side of the Keccak core. Takes the 1600-bit state produced by the permutation and streams the digest out one 64-bit lane per cycle over a valid/ready handshake. It reproduces exactly the lane ordering that the round logic packs into its state vector. With the XOF option compiled in, it keeps squeezing beyond one rate block by requesting further permutations.

---
 rtl/keccak_squeeze.sv | 160 ++++++++++++++++
 tb/tb_keccak_squeeze.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze.sv
// keccak_squeeze
// Output side of the Keccak core. Captures the rate lanes of a finished
// permutation and streams them out one 64-bit lane per cycle over a
// valid/ready handshake. Lane k is state_in[1599-64k -: 64] (row-major, x fastest).
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   state_in        1600-bit permutation result
//   state_valid     one-cycle pulse qualifying state_in
//   dout            current lane (no byte swap)
//   dout_valid      dout holds a lane
//   dout_ready      consumer accepts dout
//   dout_last       current lane ends the stream
//   busy            a stream is in progress
//   xof_more        (XOF only) consumer wants more output
//   perm_req        (XOF only) one-cycle request for the next permutation
//
// Build option: define KECCAK_SQUEEZE_XOF_EN to enable extendable output
// (keeps squeezing past one rate block by requesting further permutations).
module keccak_squeeze #(
  parameter int RATE_LANES   = 9,
  parameter int DIGEST_LANES = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1599:0] state_in,
  input  logic          state_valid,
  output logic [63:0]   dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy
`ifdef KECCAK_SQUEEZE_XOF_EN
  ,
  input  logic          xof_more,
  output logic          perm_req
`endif
);

  localparam int BUF_W = RATE_LANES * 64;
  localparam int CNT_W = $clog2(RATE_LANES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OUT  = 2'd1;
`ifdef KECCAK_SQUEEZE_XOF_EN
  localparam logic [1:0] ST_WAIT_PERM = 2'd2;
  localparam logic [CNT_W-1:0] LAST_RATE = CNT_W'(RATE_LANES - 1);
`else
  localparam logic [CNT_W-1:0] LAST_DIGEST = CNT_W'(DIGEST_LANES - 1);
`endif

  logic [1:0]       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
  logic             hs_s;
`ifdef KECCAK_SQUEEZE_XOF_EN
  logic             perm_req_q, perm_req_d;
`endif

  // Outputs come straight from flops; the top lane of the buffer is always
  // the one on offer, so dout is stable while stalled.
  assign dout       = buf_q[BUF_W-1 -: 64];
  assign dout_valid = (state_q == ST_OUT);
  assign busy       = (state_q != ST_IDLE);
  assign hs_s       = dout_valid & dout_ready;
`ifdef KECCAK_SQUEEZE_XOF_EN
  assign dout_last  = dout_valid & ~xof_more;
  assign perm_req   = perm_req_q;
`else
  assign dout_last  = dout_valid & (lane_cnt_q == LAST_DIGEST);
`endif

  // Next-state logic: capture, shift on handshake, end-of-stream decisions.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    lane_cnt_d = lane_cnt_q;
`ifdef KECCAK_SQUEEZE_XOF_EN
    perm_req_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (state_valid) begin
          buf_d      = state_in[1599 -: BUF_W];
          lane_cnt_d = {CNT_W{1'b0}};
          state_d    = ST_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (hs_s) begin
          buf_d      = buf_q << 7'd64;
          lane_cnt_d = lane_cnt_q + CNT_W'(1);
`ifdef KECCAK_SQUEEZE_XOF_EN
          if (!xof_more) begin
            // Consumer is done: drop leftover lanes so dout reads 0 when idle.
            state_d    = ST_IDLE;
            buf_d      = {BUF_W{1'b0}};
            lane_cnt_d = {CNT_W{1'b0}};
          end else if (lane_cnt_q == LAST_RATE) begin
            // Rate block exhausted but more output wanted.
            state_d    = ST_WAIT_PERM;
            perm_req_d = 1'b1;
          end else begin
            state_d = ST_OUT;
          end
`else
          if (lane_cnt_q == LAST_DIGEST) begin
            // Digest complete; unread rate lanes are discarded.
            state_d    = ST_IDLE;
            buf_d      = {BUF_W{1'b0}};
            lane_cnt_d = {CNT_W{1'b0}};
          end else begin
            state_d = ST_OUT;
          end
`endif
        end else begin
          state_d = ST_OUT;
        end
      end
`ifdef KECCAK_SQUEEZE_XOF_EN
      ST_WAIT_PERM: begin
        if (state_valid) begin
          buf_d      = state_in[1599 -: BUF_W];
          lane_cnt_d = {CNT_W{1'b0}};
          state_d    = ST_OUT;
        end else begin
          state_d = ST_WAIT_PERM;
        end
      end
`endif
      default: begin
        state_d    = ST_IDLE;
        buf_d      = {BUF_W{1'b0}};
        lane_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= {BUF_W{1'b0}};
      lane_cnt_q <= {CNT_W{1'b0}};
`ifdef KECCAK_SQUEEZE_XOF_EN
      perm_req_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      lane_cnt_q <= lane_cnt_d;
`ifdef KECCAK_SQUEEZE_XOF_EN
      perm_req_q <= perm_req_d;
`endif
    end
  end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Self-checking bench for keccak_squeeze. Expected lanes are taken from the
// stream definition: lane k = state_in[1599-64k -: 64].
module tb_keccak_squeeze;

  localparam int D = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1599:0] state_in;
  logic          state_valid;
  logic [63:0]   dout;
  logic          dout_valid, dout_ready, dout_last, busy;
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

`ifdef KECCAK_SQUEEZE_XOF_EN
  logic xof_more, perm_req;
  int   perm_cnt = 0;

  keccak_squeeze dut (
    .clk(clk), .reset(reset), .state_in(state_in), .state_valid(state_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .xof_more(xof_more), .perm_req(perm_req)
  );

  // Count cycles with perm_req high.
  always @(negedge clk) if (perm_req === 1'b1) perm_cnt++;
`else
  logic [63:0] dout1;
  logic        sv1, valid1, ready1, last1, busy1;

  keccak_squeeze dut (
    .clk(clk), .reset(reset), .state_in(state_in), .state_valid(state_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy)
  );

  keccak_squeeze #(.RATE_LANES(1), .DIGEST_LANES(1)) dut1 (
    .clk(clk), .reset(reset), .state_in(state_in), .state_valid(sv1),
    .dout(dout1), .dout_valid(valid1), .dout_ready(ready1),
    .dout_last(last1), .busy(busy1)
  );
`endif

  typedef struct {
    logic [63:0] exp_dout;
    logic        exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_of(input logic [1599:0] s, input int k);
    return s[1599-64*k -: 64];
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifndef KECCAK_SQUEEZE_XOF_EN
  // mode 0: ready pattern 1,0,0 repeating; 1: random; else always 1.
  task automatic stream_check(input logic [1599:0] st, input int mode, input bit inject);
    int          idx = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [63:0] hd = 64'd0;
    logic        hl = 1'b0;
    state_in    = st;
    state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
    while (idx < D && cyc < 200) begin
      case (mode)
        0:       dout_ready = (cyc % 3 == 0);
        1:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b1;
      endcase
      if (inject && cyc == 1) begin
        state_in    = ~st;
        state_valid = 1'b1;
      end else begin
        state_valid = 1'b0;
      end
      chk("valid_held", {63'd0, dout_valid}, 64'd1);
      if (stalled) begin
        chk("stall_dout", dout, hd);
        chk("stall_last", {63'd0, dout_last}, {63'd0, hl});
      end
      if (dout_ready) begin
        chk("lane", dout, lane_of(st, idx));
        chk("last", {63'd0, dout_last}, {63'd0, (idx == D - 1)});
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hd = dout;
        hl = dout_last;
      end
      cyc++;
      tick();
    end
    state_valid = 1'b0;
    dout_ready  = 1'b0;
    state_in    = st;
    chk("stream_len", 64'(idx), 64'(D));
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("valid_end", {63'd0, dout_valid}, 64'd0);
  endtask
`endif

  initial begin
    logic [1599:0] st;
    logic [1599:0] st2;
    vec_t          tbl [D];

    reset = 1'b1; state_valid = 1'b0; dout_ready = 1'b0; state_in = '0;
`ifdef KECCAK_SQUEEZE_XOF_EN
    xof_more = 1'b0;
`else
    sv1 = 1'b0; ready1 = 1'b0;
`endif
    tick(); tick();
    chk("rst_dout", dout, 64'd0);
    chk("rst_valid", {63'd0, dout_valid}, 64'd0);
    chk("rst_last", {63'd0, dout_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    tick();

    st = '0;
    for (int k = 0; k < 25; k++) st[1599-64*k -: 64] = 64'h0101_0101_0101_0101 * 64'(k);

`ifndef KECCAK_SQUEEZE_XOF_EN
    // Table: pattern state, ready held high.
    for (int k = 0; k < D; k++) begin
      tbl[k].exp_dout = 64'h0101_0101_0101_0101 * 64'(k);
      tbl[k].exp_last = (k == D - 1);
    end
    state_in = st; state_valid = 1'b1;
    tick();
    state_valid = 1'b0; dout_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      chk("tbl_valid", {63'd0, dout_valid}, 64'd1);
      chk("tbl_dout", dout, tbl[k].exp_dout);
      chk("tbl_last", {63'd0, dout_last}, {63'd0, tbl[k].exp_last});
      tick();
    end
    dout_ready = 1'b0;
    chk("tbl_busy_end", {63'd0, busy}, 64'd0);

    // Backpressure, then ignored mid-stream pulse, then back-to-back capture.
    stream_check(rand_state(), 0, 1'b0);
    stream_check(rand_state(), 2, 1'b1);
    stream_check(rand_state(), 2, 1'b0);
    for (int i = 0; i < 6; i++) stream_check(rand_state(), 1, i[0]);

    // Asynchronous reset after 3 accepted lanes.
    state_in = rand_state(); state_valid = 1'b1;
    tick();
    state_valid = 1'b0; dout_ready = 1'b1;
    tick(); tick(); tick();
    dout_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_dout", dout, 64'd0);
    chk("arst_valid", {63'd0, dout_valid}, 64'd0);
    chk("arst_last", {63'd0, dout_last}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    #1 reset = 1'b0;
    tick();
    stream_check(rand_state(), 2, 1'b0);

    // Single-lane configuration.
    st2 = rand_state();
    state_in = st2; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    chk("one_valid", {63'd0, valid1}, 64'd1);
    chk("one_last", {63'd0, last1}, 64'd1);
    chk("one_dout", dout1, lane_of(st2, 0));
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    chk("one_busy_end", {63'd0, busy1}, 64'd0);
    chk("one_valid_end", {63'd0, valid1}, 64'd0);
`else
    // XOF: 12 lanes across two permutations.
    st2 = rand_state();
    state_in = st; state_valid = 1'b1; xof_more = 1'b1;
    tick();
    state_valid = 1'b0; dout_ready = 1'b1;
    for (int idx = 0; idx < 12; idx++) begin
      xof_more = (idx != 11);
      #1;
      chk("xof_valid", {63'd0, dout_valid}, 64'd1);
      chk("xof_dout", dout, (idx < 9) ? lane_of(st, idx) : lane_of(st2, idx - 9));
      chk("xof_last", {63'd0, dout_last}, {63'd0, (idx == 11)});
      tick();
      if (idx == 8) begin
        chk("xof_perm_req", {63'd0, perm_req}, 64'd1);
        chk("xof_wait_valid", {63'd0, dout_valid}, 64'd0);
        chk("xof_wait_busy", {63'd0, busy}, 64'd1);
        tick(); tick();
        chk("xof_wait_valid2", {63'd0, dout_valid}, 64'd0);
        chk("xof_perm_low", {63'd0, perm_req}, 64'd0);
        state_in = st2; state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
      end
    end
    dout_ready = 1'b0;
    chk("xof_busy_end", {63'd0, busy}, 64'd0);
    chk("xof_perm_cnt", 64'(perm_cnt), 64'd1);

    // Reset while waiting for a permutation.
    state_in = st; state_valid = 1'b1; xof_more = 1'b1;
    tick();
    state_valid = 1'b0; dout_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    dout_ready = 1'b0;
    chk("xof_wait_busy3", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("xof_rst_busy", {63'd0, busy}, 64'd0);
    chk("xof_rst_perm", {63'd0, perm_req}, 64'd0);
    #1 reset = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
